// File: rtl/shift_arbiter.sv
// ---------------------------------------------------------------------------
// shift_arbiter
//
// Purpose:
//   Shares one funnel_shifter between two requesters, for example the ALU and
//   the load/store align path. Requesters are arbitrated round-robin. The
//   winner's operation is mapped onto the shifter's {upper, downer, shamt}
//   inputs. The result is registered onto a single valid/ready response
//   channel and tagged with the requester id. The block sustains one op per
//   cycle with one cycle of latency.
//
// Ports:
//   clk         clock; all state changes on the rising edge
//   rst_n       synchronous active-low reset
//   req0_valid  requester 0 has an op
//   req0_ready  requester 0 op is accepted this cycle when valid & ready
//   req0_op     000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, 101-111 reserved
//   req0_a      operand
//   req0_shamt  shift amount
//   req1_*      identical set of ports for requester 1
//   resp_valid  the result register holds a result
//   resp_ready  the consumer takes the result when valid & ready
//   resp_id     requester that issued the result
//   resp_data   shifted result
//   resp_err    the op was a reserved code
// ---------------------------------------------------------------------------

// Generic funnel shifter. dir=0 returns the low half of {upper,downer}>>shamt.
// dir=1 returns the high half of {upper,downer}<<shamt.
module funnel_shifter #(
  parameter int N    = 5,
  parameter int XLEN = 2**N
) (
  input  logic            dir,
  input  logic [XLEN-1:0] upper,
  input  logic [XLEN-1:0] downer,
  input  logic [N-1:0]    shamt,
  output logic [XLEN-1:0] result
);

  logic [2*XLEN-1:0] cat;
  logic [2*XLEN-1:0] shifted;

  assign cat     = {upper, downer};
  assign shifted = dir ? (cat << shamt) : (cat >> shamt);
  assign result  = dir ? shifted[2*XLEN-1:XLEN] : shifted[XLEN-1:0];

endmodule

module shift_arbiter #(
  parameter  int N    = 5,
  localparam int XLEN = 2**N
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [2:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [N-1:0]    req0_shamt,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [2:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [N-1:0]    req1_shamt,

  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err
);

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROR = 3'b011,
    OP_ROL = 3'b100
  } op_e;

  logic            rr_last;
  logic            grant;
  logic            can_accept;
  logic            handshake;

  logic [2:0]      sel_op;
  logic [XLEN-1:0] sel_a;
  logic [N-1:0]    sel_shamt;

  logic [XLEN-1:0] fs_upper;
  logic [XLEN-1:0] fs_downer;
  logic [N-1:0]    fs_shamt;
  logic [XLEN-1:0] fs_result;
  logic            op_err;

  // Grant is a pure function of the valids. When both requesters are valid,
  // the requester that did not win last time wins. With no valids the grant
  // still points somewhere, but no handshake can occur.
  always_comb begin
    grant = ~rr_last;
    if (req0_valid && req1_valid) begin
      grant = ~rr_last;
    end else if (req1_valid) begin
      grant = 1'b1;
    end else if (req0_valid) begin
      grant = 1'b0;
    end
  end

  // The output register has no skid buffer. A new op can only enter when the
  // register is empty or is being drained in the same cycle.
  assign can_accept = ~resp_valid | resp_ready;
  assign req0_ready = can_accept & ~grant & rst_n;
  assign req1_ready = can_accept &  grant & rst_n;
  assign handshake  = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  always_comb begin
    sel_op    = req0_op;
    sel_a     = req0_a;
    sel_shamt = req0_shamt;
    if (grant) begin
      sel_op    = req1_op;
      sel_a     = req1_a;
      sel_shamt = req1_shamt;
    end
  end

  // Every op is expressed as a right funnel shift. Left-going shifts use
  // XLEN-s. Because XLEN is a power of two, XLEN-s modulo 2**N is simply the
  // N-bit negation of s. The SLL s=0 case is split out because a shift by
  // XLEN does not fit in N bits.
  always_comb begin
    fs_upper  = '0;
    fs_downer = sel_a;
    fs_shamt  = sel_shamt;
    op_err    = 1'b0;
    case (sel_op)
      OP_SLL: begin
        if (sel_shamt == '0) begin
          fs_upper  = '0;
          fs_downer = sel_a;
          fs_shamt  = '0;
        end else begin
          fs_upper  = sel_a;
          fs_downer = '0;
          fs_shamt  = -sel_shamt;
        end
      end
      OP_SRL: begin
        fs_upper = '0;
      end
      OP_SRA: begin
        fs_upper = {XLEN{sel_a[XLEN-1]}};
      end
      OP_ROR: begin
        fs_upper = sel_a;
      end
      OP_ROL: begin
        fs_upper = sel_a;
        fs_shamt = -sel_shamt;
      end
      default: begin
        fs_upper  = '0;
        fs_downer = '0;
        fs_shamt  = '0;
        op_err    = 1'b1;
      end
    endcase
  end

  funnel_shifter #(.N(N), .XLEN(XLEN)) u_funnel (
    .dir    (1'b0),
    .upper  (fs_upper),
    .downer (fs_downer),
    .shamt  (fs_shamt),
    .result (fs_result)
  );

  // Response register. An accepted op always overwrites the register, which
  // covers the drain-and-accept case. An unaccepted drain empties the register.
  // A stalled consumer leaves every resp_* field untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      rr_last    <= 1'b1;
    end else if (handshake) begin
      resp_valid <= 1'b1;
      resp_id    <= grant;
      resp_data  <= op_err ? '0 : fs_result;
      resp_err   <= op_err;
      rr_last    <= grant;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shift_arbiter
//
// Purpose:
//   Self-checking bench for shift_arbiter. A behavioural model tracks the
//   round-robin pointer and the occupancy of the output register. Expected
//   results are computed from plain shift and rotate semantics and pushed to a
//   queue when an accept is predicted. They are compared when the result
//   appears on the response channel.
// ---------------------------------------------------------------------------
module tb_shift_arbiter;

  localparam int N    = 5;
  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            req0_valid, req1_valid;
  logic            req0_ready, req1_ready;
  logic [2:0]      req0_op, req1_op;
  logic [XLEN-1:0] req0_a, req1_a;
  logic [N-1:0]    req0_shamt, req1_shamt;
  logic            resp_valid, resp_ready, resp_id, resp_err;
  logic [XLEN-1:0] resp_data;

  typedef struct packed {
    logic            id;
    logic [XLEN-1:0] data;
    logic            err;
  } exp_t;

  typedef struct {
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [N-1:0]    s;
    logic [XLEN-1:0] want;
  } vec_t;

  exp_t exp_q[$];
  logic m_rr_last;
  logic m_valid;
  int   total;
  int   bad;

  shift_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_shamt (req0_shamt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_shamt (req1_shamt),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shifter built from single-bit rotates and native operators,
  // deliberately unrelated to the funnel mapping.
  function automatic logic [XLEN-1:0] ref_shift(input logic [2:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [N-1:0] s);
    logic [XLEN-1:0] r;
    r = a;
    case (op)
      3'd0: r = a << s;
      3'd1: r = a >> s;
      3'd2: r = $unsigned($signed(a) >>> s);
      3'd3: for (int i = 0; i < int'(s); i++) r = {r[0], r[XLEN-1:1]};
      3'd4: for (int i = 0; i < int'(s); i++) r = {r[XLEN-2:0], r[XLEN-1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic m_grant();
    if (req0_valid && req1_valid) return ~m_rr_last;
    return req1_valid;
  endfunction

  function automatic logic m_ready(input logic idx);
    return rst_n && (!m_valid || resp_ready) && (m_grant() == idx);
  endfunction

  task automatic drive_req(input logic idx, input logic v, input logic [2:0] op,
                           input logic [XLEN-1:0] a, input logic [N-1:0] s);
    if (idx == 1'b0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_shamt = s;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_shamt = s;
    end
  endtask

  // Advances the model across one rising edge, then returns 1ns after it.
  task automatic tick();
    logic g, hs;
    exp_t e;
    g  = m_grant();
    hs = rst_n && (req0_valid || req1_valid) && (!m_valid || resp_ready);
    if (!rst_n) begin
      exp_q.delete();
      m_valid   = 1'b0;
      m_rr_last = 1'b1;
    end else begin
      if (m_valid && resp_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (hs) begin
        e.id  = g;
        e.err = g ? (req1_op > 3'd4) : (req0_op > 3'd4);
        e.data = e.err ? '0 :
                 (g ? ref_shift(req1_op, req1_a, req1_shamt)
                    : ref_shift(req0_op, req0_a, req0_shamt));
        exp_q.push_back(e);
        m_rr_last = g;
        m_valid   = 1'b1;
      end else if (resp_ready) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    resp_ready = 1'b1;
    drive_req(1'b0, 1'b1, 3'd1, 32'h0000_00F0, 5'd4);
    drive_req(1'b1, 1'b1, 3'd0, 32'h0000_000F, 5'd4);
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
      end
      tick();
      total++;
      if (resp_valid !== 1'b0 || resp_id !== 1'b0 || resp_data !== '0 || resp_err !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_resp: got v=%b id=%b d=%h e=%b want all 0",
                 resp_valid, resp_id, resp_data, resp_err);
      end
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL first_grant: got %b%b want 10", req0_ready, req1_ready);
    end
    tick();
    total++;
    if (exp_q.size() == 0 || resp_valid !== 1'b1 || resp_id !== exp_q[0].id ||
        resp_id !== 1'b0 || resp_data !== exp_q[0].data || resp_err !== exp_q[0].err) begin
      bad++;
      $display("[TB] FAIL first_resp: got v=%b id=%b d=%h want id=0 d=%h",
               resp_valid, resp_id, resp_data, 32'h0000_000F);
    end
    drive_req(1'b0, 1'b0, 3'd0, '0, '0);
    drive_req(1'b1, 1'b0, 3'd0, '0, '0);
    tick();
  endtask

  task automatic test_ops();
    vec_t vecs[14];
    logic idx;
    vecs = '{
      '{3'd2, 32'h8000_0010, 5'd4,  32'hF800_0001},
      '{3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000},
      '{3'd0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF},
      '{3'd4, 32'h8000_0001, 5'd1,  32'h0000_0003},
      '{3'd3, 32'h0000_0001, 5'd1,  32'h8000_0000},
      '{3'd1, 32'h8000_0000, 5'd31, 32'h0000_0001},
      '{3'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF},
      '{3'd3, 32'h8000_0001, 5'd31, 32'h0000_0003},
      '{3'd4, 32'h0000_0001, 5'd31, 32'h8000_0000},
      '{3'd1, 32'h1234_5678, 5'd0,  32'h1234_5678},
      '{3'd2, 32'h8765_4321, 5'd0,  32'h8765_4321},
      '{3'd3, 32'hCAFE_F00D, 5'd0,  32'hCAFE_F00D},
      '{3'd4, 32'hCAFE_F00D, 5'd0,  32'hCAFE_F00D},
      '{3'd5, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000}
    };
    resp_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      idx = i[0];
      drive_req(~idx, 1'b0, 3'd0, '0, '0);
      drive_req(idx, 1'b1, vecs[i].op, vecs[i].a, vecs[i].s);
      #1;
      total++;
      if ((idx ? req1_ready : req0_ready) !== 1'b1) begin
        bad++;
        $display("[TB] FAIL op_ready[%0d]: got 0 want 1", i);
      end
      tick();
      total++;
      if (exp_q.size() == 0 || resp_valid !== 1'b1 || resp_id !== exp_q[0].id ||
          resp_data !== exp_q[0].data || resp_err !== exp_q[0].err) begin
        bad++;
        $display("[TB] FAIL op_resp[%0d]: got v=%b id=%b d=%h e=%b", i,
                 resp_valid, resp_id, resp_data, resp_err);
      end
      total++;
      if (resp_data !== vecs[i].want) begin
        bad++;
        $display("[TB] FAIL op_value[%0d]: got %h want %h", i, resp_data, vecs[i].want);
      end
    end
    drive_req(1'b0, 1'b0, 3'd0, '0, '0);
    drive_req(1'b1, 1'b0, 3'd0, '0, '0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic prev_id;
    logic g;
    resp_ready = 1'b1;
    drive_req(1'b0, 1'b1, 3'($urandom_range(0, 4)), $urandom, 5'($urandom));
    drive_req(1'b1, 1'b1, 3'($urandom_range(0, 4)), $urandom, 5'($urandom));
    prev_id = m_rr_last;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if (req0_ready !== m_ready(1'b0) || req1_ready !== m_ready(1'b1)) begin
        bad++;
        $display("[TB] FAIL b2b_ready[%0d]: got %b%b want %b%b", i,
                 req0_ready, req1_ready, m_ready(1'b0), m_ready(1'b1));
      end
      g = m_grant();
      tick();
      total++;
      if (exp_q.size() == 0 || resp_valid !== 1'b1 || resp_id !== exp_q[0].id ||
          resp_id === prev_id || resp_data !== exp_q[0].data || resp_err !== exp_q[0].err) begin
        bad++;
        $display("[TB] FAIL b2b_resp[%0d]: got v=%b id=%b d=%h prev_id=%b", i,
                 resp_valid, resp_id, resp_data, prev_id);
      end
      prev_id = resp_id;
      drive_req(g, 1'b1, 3'($urandom_range(0, 4)), $urandom, 5'($urandom));
    end
  endtask

  task automatic test_stall();
    exp_t held;
    logic g;
    resp_ready = 1'b0;
    held = '{id: resp_id, data: resp_data, err: resp_err};
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL stall_ready[%0d]: got %b%b want 00", i, req0_ready, req1_ready);
      end
      tick();
      total++;
      if (exp_q.size() != 1 || resp_valid !== 1'b1 || resp_id !== held.id ||
          resp_data !== held.data || resp_err !== held.err ||
          resp_data !== exp_q[0].data) begin
        bad++;
        $display("[TB] FAIL stall_hold[%0d]: got v=%b id=%b d=%h want id=%b d=%h", i,
                 resp_valid, resp_id, resp_data, held.id, held.data);
      end
    end
    resp_ready = 1'b1;
    #1;
    g = m_grant();
    total++;
    if ((g ? req1_ready : req0_ready) !== 1'b1) begin
      bad++;
      $display("[TB] FAIL drain_accept_ready: got 0 want 1 for req%0d", g);
    end
    tick();
    total++;
    if (exp_q.size() != 1 || resp_valid !== 1'b1 || resp_id !== exp_q[0].id ||
        resp_data !== exp_q[0].data || resp_err !== exp_q[0].err) begin
      bad++;
      $display("[TB] FAIL drain_accept_resp: got v=%b id=%b d=%h", resp_valid, resp_id, resp_data);
    end
    drive_req(1'b0, 1'b0, 3'd0, '0, '0);
    drive_req(1'b1, 1'b0, 3'd0, '0, '0);
    tick();
    total++;
    if (resp_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL drain_empty: got v=%b want 0", resp_valid);
    end
  endtask

  task automatic test_reserved_reset();
    resp_ready = 1'b1;
    drive_req(1'b1, 1'b1, 3'b111, 32'hA5A5_A5A5, 5'd7);
    tick();
    total++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 32'h0 || resp_id !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reserved: got v=%b e=%b d=%h id=%b want 1 1 0 1",
               resp_valid, resp_err, resp_data, resp_id);
    end
    drive_req(1'b1, 1'b0, 3'd0, '0, '0);
    resp_ready = 1'b0;
    rst_n      = 1'b0;
    tick();
    total++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_discard: got v=%b e=%b want 0 0", resp_valid, resp_err);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (resp_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL post_reset_idle: got v=%b want 0", resp_valid);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    m_rr_last = 1'b1;
    m_valid   = 1'b0;
    rst_n     = 1'b0;
    resp_ready = 1'b0;
    drive_req(1'b0, 1'b0, 3'd0, '0, '0);
    drive_req(1'b1, 1'b0, 3'd0, '0, '0);
    test_reset();
    test_ops();
    test_back_to_back();
    test_stall();
    test_reserved_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
